// File: rtl/c2_line_memory_if.sv
// rtl/c2_line_memory_if.sv - C2 line bus signal bundle between the bus resolver and the line memory
// Ports (per modport, slave = memory side):
//   c2_addr     line address, sampled with a command
//   c2_cmd_in   command seen on the bus
//   c2_cmd_out  command driven by the memory (RESPONSE or NOP)
//   c2_cmd_oe   memory owns the cmd wire
//   c2_data_in  write beat from the bus
//   c2_data_out read beat driven by the memory
//   c2_data_oe  memory owns the data wire
//   busy        memory is not idle
interface c2_line_memory_if #(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_BITS  = 15
);
    logic [ADDR_BITS-1:0]    c2_addr;
    logic [1:0]              c2_cmd_in;
    logic [1:0]              c2_cmd_out;
    logic                    c2_cmd_oe;
    logic [DATA_BYTES*8-1:0] c2_data_in;
    logic [DATA_BYTES*8-1:0] c2_data_out;
    logic                    c2_data_oe;
    logic                    busy;

    modport master (
        output c2_addr, c2_cmd_in, c2_data_in,
        input  c2_cmd_out, c2_cmd_oe, c2_data_out, c2_data_oe, busy
    );

    modport slave (
        input  c2_addr, c2_cmd_in, c2_data_in,
        output c2_cmd_out, c2_cmd_oe, c2_data_out, c2_data_oe, busy
    );
endinterface

// File: rtl/c2_line_memory.sv
// rtl/c2_line_memory.sv - parametrised C2 line backing store with programmable response latency
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-low reset
//   c2     C2 bus bundle (slave side): address, command in/out, data in/out, output enables, busy
// Commands: C2_NOP=0, C2_READ_LINE=1, C2_WRITE_LINE=2, C2_RESPONSE=3.
module c2_line_memory #(
    parameter int DATA_BYTES = 2,
    parameter int LINE_BYTES = 16,
    parameter int MEM_LINES  = 32768,
    parameter int ADDR_BITS  = 15,
    parameter int LATENCY    = 100
) (
    input  logic             clk,
    input  logic             reset,
    c2_line_memory_if.slave  c2
);
    localparam int BEATS = LINE_BYTES / DATA_BYTES;
    localparam int LIDX  = $clog2(MEM_LINES);
    localparam int DW    = DATA_BYTES * 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WORDS = MEM_LINES * BEATS;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_READ_LINE  = 2'd1;
    localparam logic [1:0] C2_WRITE_LINE = 2'd2;
    localparam logic [1:0] C2_RESPONSE   = 2'd3;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WR_BURST, WAIT, RD_RESP, WR_RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [LIDX-1:0]   idx_q, idx_d;
    logic              op_rd_q, op_rd_d;
    logic              cmd_oe_q, cmd_oe_d;
    logic [1:0]        cmd_out_q, cmd_out_d;
    logic              data_oe_q, data_oe_d;
    logic [DW-1:0]     data_out_q, data_out_d;
    logic              busy_q, busy_d;

    logic              mem_we;
    logic [LIDX-1:0]   mem_widx;
    logic [BW-1:0]     mem_wbeat;
    logic [DW-1:0]     mem_q [WORDS];

    // Upper address bits are intentionally dropped: lines wrap modulo MEM_LINES.
    logic [LIDX-1:0]   addr_idx;
    logic              unused_addr;
    assign addr_idx    = c2.c2_addr[LIDX-1:0];
    assign unused_addr = ^c2.c2_addr;

    function automatic logic [AW-1:0] word_addr(input logic [LIDX-1:0] idx,
                                                input logic [BW-1:0]   beat);
        return AW'(32'(idx) * BEATS + 32'(beat));
    endfunction

    // Array is never reset so committed beats survive a reset mid-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_addr(mem_widx, mem_wbeat)] <= c2.c2_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            idx_q      <= '0;
            op_rd_q    <= 1'b0;
            cmd_oe_q   <= 1'b0;
            cmd_out_q  <= C2_NOP;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            idx_q      <= idx_d;
            op_rd_q    <= op_rd_d;
            cmd_oe_q   <= cmd_oe_d;
            cmd_out_q  <= cmd_out_d;
            data_oe_q  <= data_oe_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        idx_d     = idx_q;
        op_rd_d   = op_rd_q;
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wbeat = beat_q;
        case (state_q)
            IDLE: begin
                if (c2.c2_cmd_in == C2_READ_LINE) begin
                    idx_d   = addr_idx;
                    op_rd_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end else if (c2.c2_cmd_in == C2_WRITE_LINE) begin
                    // Beat 0 travels with the command, so commit it against the live address.
                    idx_d     = addr_idx;
                    op_rd_d   = 1'b0;
                    mem_we    = 1'b1;
                    mem_widx  = addr_idx;
                    mem_wbeat = '0;
                    if (BEATS == 1) begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end else begin
                        beat_d  = BW'(1);
                        state_d = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                mem_we = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    beat_d  = '0;
                    state_d = op_rd_q ? RD_RESP : WR_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RD_RESP: begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            WR_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each
    // response cycle lines up with the state it belongs to.
    always_comb begin
        cmd_oe_d   = 1'b0;
        cmd_out_d  = C2_NOP;
        data_oe_d  = 1'b0;
        data_out_d = '0;
        busy_d     = (state_d != IDLE);
        if (state_d == RD_RESP) begin
            cmd_oe_d   = 1'b1;
            cmd_out_d  = C2_RESPONSE;
            data_oe_d  = 1'b1;
            data_out_d = mem_q[word_addr(idx_q, beat_d)];
        end else if (state_d == WR_RESP) begin
            cmd_oe_d  = 1'b1;
            cmd_out_d = C2_RESPONSE;
        end
    end

    assign c2.c2_cmd_oe   = cmd_oe_q;
    assign c2.c2_cmd_out  = cmd_out_q;
    assign c2.c2_data_oe  = data_oe_q;
    assign c2.c2_data_out = data_out_q;
    assign c2.busy        = busy_q;
endmodule

// File: tb/tb_c2_line_memory.sv
// tb/tb_c2_line_memory.sv - scoreboard bench for c2_line_memory (main config plus single-beat, latency-1 config)
module tb_c2_line_memory;
    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    typedef struct {
        int          cyc;
        logic        doe;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q6[$];

    c2_line_memory_if #(.DATA_BYTES(2), .ADDR_BITS(4)) b0 ();
    c2_line_memory_if #(.DATA_BYTES(2), .ADDR_BITS(4)) b6 ();

    c2_line_memory #(
        .DATA_BYTES(2), .LINE_BYTES(4), .MEM_LINES(8), .ADDR_BITS(4), .LATENCY(4)
    ) u0 (
        .clk   (clk),
        .reset (rst_n),
        .c2    (b0.slave)
    );

    c2_line_memory #(
        .DATA_BYTES(2), .LINE_BYTES(2), .MEM_LINES(8), .ADDR_BITS(4), .LATENCY(1)
    ) u6 (
        .clk   (clk),
        .reset (rst_n),
        .c2    (b6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (b0.c2_cmd_oe === 1'b1) begin
            if (q0.size() == 0) begin
                chk("resp0_unexpected", b0.c2_cmd_oe, 0);
            end else begin
                e = q0.pop_front();
                chk("resp0_cycle", cyc, e.cyc);
                chk("resp0_cmd", b0.c2_cmd_out, RESP);
                chk("resp0_data_oe", b0.c2_data_oe, e.doe);
                if (e.doe) chk("resp0_data", b0.c2_data_out, e.data);
            end
        end else begin
            chk("idle0_outputs", {b0.c2_cmd_out, b0.c2_data_oe, b0.c2_data_out}, 0);
        end
    end

    always @(negedge clk) begin : mon6
        exp_t e;
        if (b6.c2_cmd_oe === 1'b1) begin
            if (q6.size() == 0) begin
                chk("resp6_unexpected", b6.c2_cmd_oe, 0);
            end else begin
                e = q6.pop_front();
                chk("resp6_cycle", cyc, e.cyc);
                chk("resp6_cmd", b6.c2_cmd_out, RESP);
                chk("resp6_data_oe", b6.c2_data_oe, e.doe);
                if (e.doe) chk("resp6_data", b6.c2_data_out, e.data);
            end
        end else begin
            chk("idle6_outputs", {b6.c2_cmd_out, b6.c2_data_oe, b6.c2_data_out}, 0);
        end
    end

    // Write response expected LATENCY after the last beat: T0+1+4.
    task automatic do_write(input logic [3:0] a, input logic [15:0] d0, input logic [15:0] d1,
                            input bit expect_resp);
        int t0;
        @(negedge clk);
        b0.c2_cmd_in = WR; b0.c2_addr = a; b0.c2_data_in = d0;
        t0 = cyc + 1;
        if (expect_resp) q0.push_back('{t0 + 5, 1'b0, 16'h0});
        @(negedge clk);
        b0.c2_cmd_in = NOP; b0.c2_data_in = d1;
        if (expect_resp) chk("busy_in_burst", b0.busy, 1);
        @(negedge clk);
        b0.c2_data_in = 16'h0;
    endtask

    // Read response beats expected at T0+4 and T0+5.
    task automatic do_read(input logic [3:0] a, input logic [15:0] d0, input logic [15:0] d1,
                           input bit expect_resp);
        int t0;
        @(negedge clk);
        b0.c2_cmd_in = RD; b0.c2_addr = a;
        t0 = cyc + 1;
        if (expect_resp) begin
            q0.push_back('{t0 + 4, 1'b1, d0});
            q0.push_back('{t0 + 5, 1'b1, d1});
        end
        @(negedge clk);
        b0.c2_cmd_in = NOP;
    endtask

    task automatic wait_idle(input bit six);
        int n = 0;
        while (n < 40 && (six ? (b6.busy || q6.size() != 0) : (b0.busy || q0.size() != 0))) begin
            @(negedge clk);
            n++;
        end
        chk(six ? "wait_idle6_bound" : "wait_idle0_bound", 32'(n < 40), 1);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        b0.c2_cmd_in = NOP; b0.c2_addr = '0; b0.c2_data_in = '0;
        b6.c2_cmd_in = NOP; b6.c2_addr = '0; b6.c2_data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_oe", b0.c2_cmd_oe, 0);
        chk("rst_data_oe", b0.c2_data_oe, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_cmd_out", b0.c2_cmd_out, NOP);
        rst_n = 1'b1;
        @(negedge clk);

        // 1/2: write then read line 5
        do_write(4'd5, 16'h0201, 16'h0403, 1'b1);
        wait_idle(1'b0);
        do_read(4'd5, 16'h0201, 16'h0403, 1'b1);
        wait_idle(1'b0);
        chk("busy_after_read", b0.busy, 0);
        chk("cmd_oe_after_read", b0.c2_cmd_oe, 0);

        // 3: write issued during read WAIT is ignored
        do_write(4'd3, 16'h1111, 16'h2222, 1'b1);
        wait_idle(1'b0);
        do_read(4'd5, 16'h0201, 16'h0403, 1'b1);
        do_write(4'd3, 16'hDEAD, 16'hBEEF, 1'b0);
        wait_idle(1'b0);
        do_read(4'd3, 16'h1111, 16'h2222, 1'b1);
        wait_idle(1'b0);

        // 4: reset during read WAIT kills the pending response
        do_read(4'd5, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("busy_before_reset", b0.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cmd_oe", b0.c2_cmd_oe, 0);
        chk("async_rst_data_oe", b0.c2_data_oe, 0);
        chk("async_rst_busy", b0.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_read(4'd5, 16'h0201, 16'h0403, 1'b1);
        wait_idle(1'b0);

        // 5: address wrap, 9 mod 8 = 1
        do_write(4'd9, 16'hAAAA, 16'hBBBB, 1'b1);
        wait_idle(1'b0);
        do_read(4'd1, 16'hAAAA, 16'hBBBB, 1'b1);
        wait_idle(1'b0);

        // 6: single beat, latency 1
        @(negedge clk);
        b6.c2_cmd_in = WR; b6.c2_addr = 4'd0; b6.c2_data_in = 16'h5A5A;
        t0 = cyc + 1;
        q6.push_back('{t0 + 1, 1'b0, 16'h0});
        @(negedge clk);
        b6.c2_cmd_in = NOP; b6.c2_data_in = 16'h0;
        wait_idle(1'b1);
        @(negedge clk);
        b6.c2_cmd_in = RD; b6.c2_addr = 4'd0;
        t0 = cyc + 1;
        q6.push_back('{t0 + 1, 1'b1, 16'h5A5A});
        @(negedge clk);
        b6.c2_cmd_in = NOP;
        wait_idle(1'b1);
        @(negedge clk);
        b6.c2_cmd_in = WR; b6.c2_addr = 4'd11; b6.c2_data_in = 16'h1234;
        t0 = cyc + 1;
        q6.push_back('{t0 + 1, 1'b0, 16'h0});
        @(negedge clk);
        b6.c2_cmd_in = NOP; b6.c2_data_in = 16'h0;
        wait_idle(1'b1);
        @(negedge clk);
        b6.c2_cmd_in = RD; b6.c2_addr = 4'd3;
        t0 = cyc + 1;
        q6.push_back('{t0 + 1, 1'b1, 16'h1234});
        @(negedge clk);
        b6.c2_cmd_in = NOP;
        wait_idle(1'b1);

        chk("q0_drained", q0.size(), 0);
        chk("q6_drained", q6.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
